// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   fetch_state_t       : 2-bit fetch controller state encoding
//   OPCODE_MSB/LSB      : position of the opcode field in an instruction word
//   HALT_OPCODE_DEFAULT : opcode value that stops instruction fetch
//   opcode_of()         : extracts the opcode field from an instruction word
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 29;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = 3'b111;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller.
// Drives the PC to an external instruction memory (combinational read),
// registers the returned word toward decode with a valid/ready handshake,
// follows redirects from execute and stops on the halt opcode.
//
// Ports
//   clk             : clock, all state changes on the rising edge
//   rst             : synchronous active-high reset
//   start           : pulse that leaves IDLE and begins fetching
//   inst_address    : current PC, address presented to instruction memory
//   read_data       : instruction word read from inst_address
//   redirect_valid  : branch/jump request, highest priority outside IDLE
//   redirect_target : new PC on a redirect
//   inst_out        : registered instruction toward decode
//   pc_out          : address inst_out was fetched from
//   inst_valid      : inst_out/pc_out hold a valid instruction
//   inst_ready      : decode accepts inst_out this cycle
//   halted          : high while in the HALT state
module fetch_controller
  import cpu_pkg::*;
#(
  parameter logic [15:0] START_ADDR  = 16'h0000,
  parameter logic [2:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] inst_address,
  input  logic [31:0] read_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic [31:0] inst_out,
  output logic [15:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        halted
);

  fetch_state_t state;
  logic [15:0]  pc_p0;
  logic         slot_free;
  logic         halt_word;

  assign inst_address = pc_p0;

  // The output slot can take a new word when it is empty or being drained.
  assign slot_free = !inst_valid || inst_ready;
  assign halt_word = (opcode_of(read_data) == HALT_OPCODE);

  // Stage p0 -> p1: PC addresses memory, returned word is registered out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc_p0      <= START_ADDR;
      inst_out   <= '0;
      pc_out     <= '0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else if (redirect_valid && (state != ST_IDLE)) begin
      // Redirect discards whatever is pending, including a delivered halt.
      state      <= ST_FETCH;
      pc_p0      <= redirect_target;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_FETCH;
        end
        ST_FETCH, ST_STALL: begin
          if (slot_free) begin
            inst_out   <= read_data;
            pc_out     <= pc_p0;
            inst_valid <= 1'b1;
            if (halt_word) begin
              // PC stays on the halt instruction's address.
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              pc_p0 <= pc_p0 + 16'd1;
              state <= ST_FETCH;
            end
          end else begin
            state <= ST_STALL;
          end
        end
        ST_HALT: begin
          if (inst_ready) inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] inst_address;
  logic [31:0] read_data;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [31:0] inst_out;
  logic [15:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        halted;

  int tests_run;
  int tests_failed;

  fetch_controller #(
    .START_ADDR (16'h0000),
    .HALT_OPCODE(3'b111)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .inst_address   (inst_address),
    .read_data      (read_data),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .halted         (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: two special words, otherwise the address itself.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 32'h070000FF;
      16'h0005: return 32'hE0000000;
      default:  return {16'h0000, a};
    endcase
  endfunction

  assign read_data = mem_word(inst_address);

  typedef struct {
    logic        rst;
    logic        start;
    logic        rv;
    logic [15:0] rt;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic [15:0] ep;
    logic [15:0] ea;
    logic        eh;
  } vec_t;

  localparam int NV = 26;
  vec_t vt[NV];

  function automatic vec_t mk(input logic r, input logic s, input logic rv,
                              input logic [15:0] rt, input logic rdy,
                              input logic ev, input logic [31:0] ei,
                              input logic [15:0] ep, input logic [15:0] ea,
                              input logic eh);
    vec_t v;
    v.rst = r; v.start = s; v.rv = rv; v.rt = rt; v.rdy = rdy;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rv,
                      input logic [15:0] rt, input logic rdy);
    rst = r; start = s; redirect_valid = rv; redirect_target = rt; inst_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] ei,
                         input logic [15:0] ep, input logic [15:0] ea, input logic eh);
    chk({tag, " inst_valid"},   {31'd0, inst_valid}, {31'd0, ev});
    chk({tag, " inst_out"},     inst_out, ei);
    chk({tag, " pc_out"},       {16'd0, pc_out}, {16'd0, ep});
    chk({tag, " inst_address"}, {16'd0, inst_address}, {16'd0, ea});
    chk({tag, " halted"},       {31'd0, halted}, {31'd0, eh});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    redirect_target = 16'h0000; inst_ready = 1'b0;

    //          rst  st   rv   rt        rdy   ev   inst           pc_out    addr      halt
    vt[0]  = mk(1,   0,   0,   16'h0000, 0,    0,   32'h00000000,  16'h0000, 16'h0000, 0); // reset
    vt[1]  = mk(0,   0,   0,   16'h0000, 1,    0,   32'h00000000,  16'h0000, 16'h0000, 0); // idle, no fetch
    vt[2]  = mk(0,   1,   0,   16'h0000, 1,    0,   32'h00000000,  16'h0000, 16'h0000, 0); // start -> FETCH
    vt[3]  = mk(0,   0,   0,   16'h0000, 1,    1,   32'h070000FF,  16'h0000, 16'h0001, 0); // first fetch
    vt[4]  = mk(0,   0,   0,   16'h0000, 1,    1,   32'h00000001,  16'h0001, 16'h0002, 0);
    vt[5]  = mk(0,   0,   0,   16'h0000, 0,    1,   32'h00000001,  16'h0001, 16'h0002, 0); // stall 1
    vt[6]  = mk(0,   0,   0,   16'h0000, 0,    1,   32'h00000001,  16'h0001, 16'h0002, 0); // stall 2
    vt[7]  = mk(0,   0,   0,   16'h0000, 0,    1,   32'h00000001,  16'h0001, 16'h0002, 0); // stall 3
    vt[8]  = mk(0,   0,   0,   16'h0000, 1,    1,   32'h00000002,  16'h0002, 16'h0003, 0); // release
    vt[9]  = mk(0,   0,   0,   16'h0000, 0,    1,   32'h00000002,  16'h0002, 16'h0003, 0); // stall
    vt[10] = mk(0,   0,   1,   16'h000B, 0,    0,   32'h00000002,  16'h0002, 16'h000B, 0); // redirect in STALL
    vt[11] = mk(0,   0,   0,   16'h0000, 0,    1,   32'h0000000B,  16'h000B, 16'h000C, 0);
    vt[12] = mk(0,   0,   1,   16'h0005, 1,    0,   32'h0000000B,  16'h000B, 16'h0005, 0); // redirect to 5
    vt[13] = mk(0,   0,   0,   16'h0000, 0,    1,   32'hE0000000,  16'h0005, 16'h0005, 1); // halt word
    vt[14] = mk(0,   0,   0,   16'h0000, 0,    1,   32'hE0000000,  16'h0005, 16'h0005, 1); // not yet accepted
    vt[15] = mk(0,   0,   0,   16'h0000, 1,    0,   32'hE0000000,  16'h0005, 16'h0005, 1); // accepted
    vt[16] = mk(0,   1,   0,   16'h0000, 1,    0,   32'hE0000000,  16'h0005, 16'h0005, 1); // start ignored
    vt[17] = mk(0,   0,   1,   16'hFFFF, 1,    0,   32'hE0000000,  16'h0005, 16'hFFFF, 0); // redirect out of HALT
    vt[18] = mk(0,   0,   0,   16'h0000, 1,    1,   32'h0000FFFF,  16'hFFFF, 16'h0000, 0); // PC wraps
    vt[19] = mk(0,   0,   0,   16'h0000, 1,    1,   32'h070000FF,  16'h0000, 16'h0001, 0);
    vt[20] = mk(0,   0,   0,   16'h0000, 0,    1,   32'h070000FF,  16'h0000, 16'h0001, 0); // stall
    vt[21] = mk(1,   0,   0,   16'h0000, 0,    0,   32'h00000000,  16'h0000, 16'h0000, 0); // reset mid-stall
    vt[22] = mk(0,   0,   0,   16'h0000, 1,    0,   32'h00000000,  16'h0000, 16'h0000, 0); // no fetch w/o start
    vt[23] = mk(0,   0,   1,   16'h0033, 1,    0,   32'h00000000,  16'h0000, 16'h0000, 0); // redirect ignored in IDLE
    vt[24] = mk(0,   1,   0,   16'h0000, 1,    0,   32'h00000000,  16'h0000, 16'h0000, 0);
    vt[25] = mk(0,   0,   0,   16'h0000, 1,    1,   32'h070000FF,  16'h0000, 16'h0001, 0);

    for (int i = 0; i < NV; i++) begin
      step(vt[i].rst, vt[i].start, vt[i].rv, vt[i].rt, vt[i].rdy);
      chk_all($sformatf("vec%0d", i), vt[i].ev, vt[i].ei, vt[i].ep, vt[i].ea, vt[i].eh);
    end

    // Reset while halted with the halt word still pending, then restart.
    step(0, 0, 1, 16'h0005, 0);
    chk_all("seq redirect5", 1'b0, 32'h070000FF, 16'h0000, 16'h0005, 1'b0);
    step(0, 0, 0, 16'h0000, 0);
    chk_all("seq halt", 1'b1, 32'hE0000000, 16'h0005, 16'h0005, 1'b1);
    step(1, 1, 1, 16'h0077, 1);
    chk_all("seq rst in halt", 1'b0, 32'h00000000, 16'h0000, 16'h0000, 1'b0);
    step(0, 0, 0, 16'h0000, 1);
    chk_all("seq idle", 1'b0, 32'h00000000, 16'h0000, 16'h0000, 1'b0);
    step(0, 1, 0, 16'h0000, 1);
    step(0, 0, 0, 16'h0000, 1);
    chk_all("seq restart", 1'b1, 32'h070000FF, 16'h0000, 16'h0001, 1'b0);
    step(0, 0, 0, 16'h0000, 1);
    chk_all("seq next", 1'b1, 32'h00000001, 16'h0001, 16'h0002, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter: START_ADDR, 16'h0000, PC value loaded at reset.
REQ-002 SHALL have parameter: HALT_OPCODE, 3'b111, opcode (bits [31:29]) that halts fetch.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port: start  input  1  one-cycle pulse that begins fetching from IDLE.
REQ-006 SHALL have port: inst_address  output  16  address driven to InstructionMemory; equals the PC register.
REQ-007 SHALL have port: read_data  input  32  combinational instruction word returned by InstructionMemory.
REQ-008 SHALL have port: redirect_valid  input  1  branch/jump request from execute.
REQ-009 SHALL have port: redirect_target  input  16  new PC when redirect_valid=1.
REQ-010 SHALL have port: inst_out  output  32  registered instruction to decode.
REQ-011 SHALL have port: pc_out  output  16  address inst_out was fetched from.
REQ-012 SHALL have port: inst_valid  output  1  inst_out/pc_out hold a valid instruction.
REQ-013 SHALL have port: inst_ready  input  1  decode accepts inst_out this cycle.
REQ-014 SHALL have port: halted  output  1  high while in HALT state.

Function
REQ-015 SHALL implement states IDLE, FETCH, STALL, HALT; reset state IDLE.
REQ-016 SHALL move IDLE->FETCH on start=1; start SHALL be ignored in all other states.
REQ-017 SHALL, in FETCH when inst_valid=0 or inst_ready=1, capture read_data into inst_out and PC into pc_out, set inst_valid=1 and increment PC by 1, all in one cycle (one-cycle fetch latency, one instruction per cycle throughput).
REQ-018 SHALL move FETCH->STALL when inst_valid=1 and inst_ready=0; in STALL, PC, inst_out, pc_out and inst_valid SHALL hold unchanged.
REQ-019 SHALL move STALL->FETCH on inst_ready=1, performing the REQ-017 capture in that same cycle.
REQ-020 SHALL wrap PC from 16'hFFFF to 16'h0000 on increment without flagging an error.
REQ-021 SHALL, when a captured read_data[31:29]==HALT_OPCODE, deliver that instruction normally, not increment PC, and enter HALT; in HALT no new capture occurs, and inst_valid drops once the halt instruction is accepted.
REQ-022 SHALL treat redirect_valid=1 (in FETCH, STALL or HALT) as highest priority: PC<=redirect_target, inst_valid<=0 (pending instruction discarded), state<=FETCH; first redirected instruction appears with inst_valid=1 one cycle later.
REQ-023 SHALL ignore redirect_valid in IDLE.
REQ-024 SHALL drive halted=1 exactly when state is HALT.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, set PC=START_ADDR, inst_out=0, pc_out=0, inst_valid=0, halted=0, state=IDLE.
REQ-026 SHALL give rst priority over start, redirect_valid and inst_ready, including mid-stall or mid-halt.

Structure
REQ-027 SHALL place state encoding (2-bit IDLE/FETCH/STALL/HALT), opcode field position [31:29] and HALT_OPCODE default in shared package cpu_pkg.
REQ-028 SHALL be a single module with no sub-modules; InstructionMemory is instantiated outside, connected via inst_address/read_data.

Verification
REQ-029 SHALL check: reset, start, memory word 0x070000FF at address 0 -> one cycle later inst_out=0x070000FF, pc_out=0, inst_valid=1, inst_address=1.
REQ-030 SHALL check: inst_ready=0 for 3 cycles with pending instruction at pc_out=1 -> inst_out, pc_out, inst_address=2 held for 3 cycles; on inst_ready=1, pc_out=2 next cycle.
REQ-031 SHALL check: redirect_valid=1, target=16'h000B while in STALL -> next cycle inst_valid=0, inst_address=0x000B; following cycle pc_out=0x000B.
REQ-032 SHALL check: word 0xE0000000 at address 5 -> delivered with pc_out=5, halted=1, inst_address stays 5, inst_valid=0 after acceptance.
REQ-033 SHALL check: redirect to 16'hFFFF -> pc_out sequence 0xFFFF then 0x0000.
REQ-034 SHALL check: rst=1 during STALL with inst_valid=1 -> next cycle inst_valid=0, inst_address=START_ADDR, state IDLE, and no fetch until start.
